// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, totals and the coordinate type used by the sync,
// pixel and overlay generators.
package vga_pkg;

   localparam int DEF_CLK_DIV   = 4;
   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;

   localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef logic [9:0] coord_t;

   function automatic logic in_range(coord_t c, int lo, int hi);
      return (int'(c) >= lo) && (int'(c) <= hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to pixel/overlay consumers.
// frame_tick exists only when VGA_SYNC_FRAME_TICK_EN is defined.
interface vga_sync_gen_if;
   import vga_pkg::*;

   logic   hsync;
   logic   vsync;
   logic   video_on;
   logic   p_tick;
   coord_t pixel_x;
   coord_t pixel_y;
`ifdef VGA_SYNC_FRAME_TICK_EN
   logic   frame_tick;
`endif

`ifdef VGA_SYNC_FRAME_TICK_EN
   modport master (output hsync, vsync, video_on, p_tick, pixel_x, pixel_y, frame_tick);
   modport slave  (input  hsync, vsync, video_on, p_tick, pixel_x, pixel_y, frame_tick);
`else
   modport master (output hsync, vsync, video_on, p_tick, pixel_x, pixel_y);
   modport slave  (input  hsync, vsync, video_on, p_tick, pixel_x, pixel_y);
`endif

endinterface

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider: p_tick is high for one clk each time the divider
// sits at CLK_DIV-1; held low while rst is high.
module vga_pix_tick
   import vga_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic p_tick
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div;
   logic [DW-1:0] div_next;

   always_comb begin
      div_next = div + DW'(1);
      if (div == LAST) div_next = '0;
   end

   // p_tick is registered off div_next so it tracks div==LAST exactly,
   // including the CLK_DIV=1 case, yet stays low during reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         div    <= '0;
         p_tick <= 1'b0;
      end else begin
         div    <= div_next;
         p_tick <= (div_next == LAST);
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical counters and sync generation. Optional frame_tick
// output is enabled by defining VGA_SYNC_FRAME_TICK_EN.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int H_DISPLAY = DEF_H_DISPLAY,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_DISPLAY = DEF_V_DISPLAY,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP
) (
   input logic            clk,
   input logic            rst,
   vga_sync_gen_if.master vga
);

   localparam int H_TOT    = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOT    = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam coord_t H_LAST = coord_t'(H_TOT - 1);
   localparam coord_t V_LAST = coord_t'(V_TOT - 1);
   localparam int HS_START = H_DISPLAY + H_FP;
   localparam int HS_END   = HS_START + H_SYNC - 1;
   localparam int VS_START = V_DISPLAY + V_FP;
   localparam int VS_END   = VS_START + V_SYNC - 1;

   logic   p_tick;
   coord_t h_count, v_count;
   coord_t h_next, v_next;
   logic   hsync_q, vsync_q, video_on_q;

   vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
      .clk    (clk),
      .rst    (rst),
      .p_tick (p_tick)
   );

   always_comb begin
      h_next = h_count;
      v_next = v_count;
      if (p_tick) begin
         if (h_count == H_LAST) begin
            h_next = '0;
            v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
         end else begin
            h_next = h_count + 10'd1;
         end
      end
   end

   // Sync and blanking are decoded from the next counts so they land in the
   // same register stage as pixel_x/pixel_y.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_count    <= '0;
         v_count    <= '0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b1;
      end else begin
         h_count    <= h_next;
         v_count    <= v_next;
         hsync_q    <= !in_range(h_next, HS_START, HS_END);
         vsync_q    <= !in_range(v_next, VS_START, VS_END);
         video_on_q <= (int'(h_next) < H_DISPLAY) && (int'(v_next) < V_DISPLAY);
      end
   end

   assign vga.hsync    = hsync_q;
   assign vga.vsync    = vsync_q;
   assign vga.video_on = video_on_q;
   assign vga.p_tick   = p_tick;
   assign vga.pixel_x  = h_count;
   assign vga.pixel_y  = v_count;

`ifdef VGA_SYNC_FRAME_TICK_EN
   assign vga.frame_tick = p_tick && (h_count == H_LAST) && (v_count == V_LAST);
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default-timing instance for tick/line/reset
// behaviour and a shrunken-timing instance for whole-frame behaviour.
module tb_vga_sync_gen;
   import vga_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic rst_s;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   vga_sync_gen_if vif ();
   vga_sync_gen_if vif_s ();

   vga_sync_gen dut (
      .clk (clk),
      .rst (rst),
      .vga (vif)
   );

   // Small frame: H 8/2/3/2 (total 15, hsync 10..12), V 6/1/2/2 (total 11, vsync 7..8)
   vga_sync_gen #(
      .CLK_DIV(2), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_DISPLAY(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
   ) dut_s (
      .clk (clk),
      .rst (rst_s),
      .vga (vif_s)
   );

   // Sync-stability monitor: a sync output may only change across an edge
   // that saw p_tick or rst high.
   logic mon_en = 1'b0;
   logic ok_d = 1'b1, ok_s_d = 1'b1;
   logic hs_p, vs_p, hs_s_p, vs_s_p;
   int   viol = 0, viol_s = 0;

   always @(posedge clk) begin
      ok_d   = vif.p_tick | rst;
      ok_s_d = vif_s.p_tick | rst_s;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if ((vif.hsync !== hs_p || vif.vsync !== vs_p) && !ok_d) viol++;
         if ((vif_s.hsync !== hs_s_p || vif_s.vsync !== vs_s_p) && !ok_s_d) viol_s++;
      end
      hs_p   = vif.hsync;
      vs_p   = vif.vsync;
      hs_s_p = vif_s.hsync;
      vs_s_p = vif_s.vsync;
   end

   task automatic test_reset();
      rst   = 1'b1;
      rst_s = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (vif.pixel_x !== 10'd0) begin failures++; $display("FAIL reset_x: got %0d expected 0", vif.pixel_x); end
      checks++; if (vif.pixel_y !== 10'd0) begin failures++; $display("FAIL reset_y: got %0d expected 0", vif.pixel_y); end
      checks++; if (vif.hsync !== 1'b1) begin failures++; $display("FAIL reset_hsync: got %b expected 1", vif.hsync); end
      checks++; if (vif.vsync !== 1'b1) begin failures++; $display("FAIL reset_vsync: got %b expected 1", vif.vsync); end
      checks++; if (vif.p_tick !== 1'b0) begin failures++; $display("FAIL reset_p_tick: got %b expected 0", vif.p_tick); end
      checks++; if (vif.video_on !== 1'b1) begin failures++; $display("FAIL reset_video_on: got %b expected 1", vif.video_on); end
      checks++; if (vif_s.p_tick !== 1'b0) begin failures++; $display("FAIL reset_s_p_tick: got %b expected 0", vif_s.p_tick); end
      mon_en = 1'b1;
   endtask

   // After release, edges 4, 8, 12 are the ones that see p_tick high.
   task automatic test_first_ticks();
      logic exp_t;
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         exp_t = (k % 4 == 0);
         checks++;
         if (vif.p_tick !== exp_t) begin
            failures++; $display("FAIL first_tick_%0d: got %b expected %b", k, vif.p_tick, exp_t);
         end
         if (k == 4) begin
            checks++; if (vif.pixel_x !== 10'd0) begin failures++; $display("FAIL x_before_tick: got %0d expected 0", vif.pixel_x); end
         end
         if (k == 5) begin
            checks++; if (vif.pixel_x !== 10'd1) begin failures++; $display("FAIL x_after_tick: got %0d expected 1", vif.pixel_x); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_line();
      int ticks = 0, hs_low = 0, hs_first = -1, hs_err = 0, vo_err = 0;
      bit started = 1'b0, done = 1'b0;
      logic exp_hs, exp_vo;
      logic [9:0] prev_x = vif.pixel_x;
      for (int n = 0; n < 8000 && !done; n++) begin
         @(negedge clk);
         if (vif.pixel_x == 10'd0 && prev_x != 10'd0) begin
            if (started) done = 1'b1;
            else started = 1'b1;
         end
         if (started && !done && vif.p_tick) begin
            ticks++;
            exp_hs = !(vif.pixel_x >= 656 && vif.pixel_x <= 751);
            exp_vo = (vif.pixel_x < 640) && (vif.pixel_y < 480);
            if (vif.hsync !== exp_hs) hs_err++;
            if (vif.video_on !== exp_vo) vo_err++;
            if (vif.hsync === 1'b0) begin
               hs_low++;
               if (hs_first < 0) hs_first = int'(vif.pixel_x);
            end
         end
         prev_x = vif.pixel_x;
      end
      checks++; if (!done) begin failures++; $display("FAIL line_timeout: got no line wrap expected wrap within 8000 clk"); end
      checks++; if (ticks != 800) begin failures++; $display("FAIL line_ticks: got %0d expected 800", ticks); end
      checks++; if (hs_low != 96) begin failures++; $display("FAIL hsync_width: got %0d expected 96", hs_low); end
      checks++; if (hs_first != 656) begin failures++; $display("FAIL hsync_start: got %0d expected 656", hs_first); end
      checks++; if (hs_err != 0) begin failures++; $display("FAIL hsync_pattern: got %0d bad pixels expected 0", hs_err); end
      checks++; if (vo_err != 0) begin failures++; $display("FAIL line_video_on: got %0d bad pixels expected 0", vo_err); end
   endtask

   task automatic test_reset_at_700();
      bit found = 1'b0;
      logic exp_t;
      for (int n = 0; n < 8000 && !found; n++) begin
         @(negedge clk);
         if (vif.pixel_x == 10'd700) found = 1'b1;
      end
      checks++; if (!found) begin failures++; $display("FAIL reach_700: got no x=700 expected x=700 within 8000 clk"); end
      checks++; if (vif.hsync !== 1'b0) begin failures++; $display("FAIL hsync_at_700: got %b expected 0", vif.hsync); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (vif.pixel_x !== 10'd0) begin failures++; $display("FAIL rst700_x: got %0d expected 0", vif.pixel_x); end
      checks++; if (vif.pixel_y !== 10'd0) begin failures++; $display("FAIL rst700_y: got %0d expected 0", vif.pixel_y); end
      checks++; if (vif.hsync !== 1'b1) begin failures++; $display("FAIL rst700_hsync: got %b expected 1", vif.hsync); end
      checks++; if (vif.vsync !== 1'b1) begin failures++; $display("FAIL rst700_vsync: got %b expected 1", vif.vsync); end
      checks++; if (vif.p_tick !== 1'b0) begin failures++; $display("FAIL rst700_p_tick: got %b expected 0", vif.p_tick); end
      checks++; if (vif.video_on !== 1'b1) begin failures++; $display("FAIL rst700_video_on: got %b expected 1", vif.video_on); end
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         exp_t = (j == 3);
         checks++;
         if (vif.p_tick !== exp_t) begin
            failures++; $display("FAIL rst700_tick_%0d: got %b expected %b", j, vif.p_tick, exp_t);
         end
      end
   endtask

   task automatic test_frame();
      int ticks = 0, lines = 0, vo_ticks = 0, hs_ticks = 0, ft_count = 0;
      logic [15:0] vs_mask = '0;
      logic ft_at_wrap = 1'b0;
      bit done = 1'b0;
      rst_s = 1'b0;
      for (int n = 0; n < 2000 && !done; n++) begin
`ifdef VGA_SYNC_FRAME_TICK_EN
         if (vif_s.frame_tick === 1'b1) ft_count++;
`endif
         if (vif_s.p_tick) begin
            ticks++;
            if (vif_s.pixel_x == 10'd0) lines++;
            if (vif_s.pixel_x == 10'd0 && vif_s.vsync === 1'b0) vs_mask[vif_s.pixel_y[3:0]] = 1'b1;
            if (vif_s.video_on === 1'b1) vo_ticks++;
            if (vif_s.hsync === 1'b0) hs_ticks++;
            if (vif_s.pixel_x == 10'd14 && vif_s.pixel_y == 10'd10) begin
`ifdef VGA_SYNC_FRAME_TICK_EN
               ft_at_wrap = vif_s.frame_tick;
`endif
               done = 1'b1;
            end
         end
         @(negedge clk);
      end
      checks++; if (!done) begin failures++; $display("FAIL frame_timeout: got no wrap expected wrap within 2000 clk"); end
      checks++; if (ticks != 165) begin failures++; $display("FAIL frame_ticks: got %0d expected 165", ticks); end
      checks++; if (lines != 11) begin failures++; $display("FAIL frame_lines: got %0d expected 11", lines); end
      checks++; if (vs_mask !== 16'h0180) begin failures++; $display("FAIL vsync_lines: got %h expected 0180", vs_mask); end
      checks++; if (vo_ticks != 48) begin failures++; $display("FAIL video_on_ticks: got %0d expected 48", vo_ticks); end
      checks++; if (hs_ticks != 33) begin failures++; $display("FAIL hsync_ticks: got %0d expected 33", hs_ticks); end
      checks++; if (vif_s.pixel_x !== 10'd0 || vif_s.pixel_y !== 10'd0) begin
         failures++; $display("FAIL wrap_xy: got (%0d,%0d) expected (0,0)", vif_s.pixel_x, vif_s.pixel_y);
      end
      checks++; if (vif_s.video_on !== 1'b1) begin failures++; $display("FAIL wrap_video_on: got %b expected 1", vif_s.video_on); end
`ifdef VGA_SYNC_FRAME_TICK_EN
      checks++; if (ft_at_wrap !== 1'b1) begin failures++; $display("FAIL frame_tick_wrap: got %b expected 1", ft_at_wrap); end
      checks++; if (ft_count != 1) begin failures++; $display("FAIL frame_tick_count: got %0d expected 1", ft_count); end
`endif
   endtask

   task automatic test_midframe_reset();
      bit found = 1'b0;
      for (int n = 0; n < 2000 && !found; n++) begin
         @(negedge clk);
         if (vif_s.pixel_x == 10'd11 && vif_s.pixel_y == 10'd7) found = 1'b1;
      end
      checks++; if (!found) begin failures++; $display("FAIL reach_11_7: got no (11,7) expected (11,7) within 2000 clk"); end
      checks++; if (vif_s.hsync !== 1'b0 || vif_s.vsync !== 1'b0) begin
         failures++; $display("FAIL sync_at_11_7: got h=%b v=%b expected h=0 v=0", vif_s.hsync, vif_s.vsync);
      end
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      checks++; if (vif_s.pixel_x !== 10'd0 || vif_s.pixel_y !== 10'd0) begin
         failures++; $display("FAIL mid_rst_xy: got (%0d,%0d) expected (0,0)", vif_s.pixel_x, vif_s.pixel_y);
      end
      checks++; if (vif_s.hsync !== 1'b1 || vif_s.vsync !== 1'b1) begin
         failures++; $display("FAIL mid_rst_sync: got h=%b v=%b expected h=1 v=1", vif_s.hsync, vif_s.vsync);
      end
      checks++; if (vif_s.p_tick !== 1'b0) begin failures++; $display("FAIL mid_rst_p_tick: got %b expected 0", vif_s.p_tick); end
      @(negedge clk);
      checks++; if (vif_s.p_tick !== 1'b1) begin failures++; $display("FAIL mid_rst_first_tick: got %b expected 1", vif_s.p_tick); end
   endtask

   task automatic test_sync_stability();
      checks++; if (viol != 0) begin failures++; $display("FAIL sync_stable: got %0d changes off p_tick expected 0", viol); end
      checks++; if (viol_s != 0) begin failures++; $display("FAIL sync_stable_s: got %0d changes off p_tick expected 0", viol_s); end
   endtask

   initial begin
      rst   = 1'b1;
      rst_s = 1'b1;
      test_reset();
      test_first_ticks();
      test_line();
      test_reset_at_700();
      test_frame();
      test_midframe_reset();
      repeat (40) @(negedge clk);
      test_sync_stability();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
